// File: rtl/dot_product_acc.sv
// dot_product_acc
//   Accumulates COUNT products from an external pipelined multiplier into one
//   dot-product result. Each accepted operand pair is tracked through a
//   LATENCY-deep valid delay line so that the matching product is added when
//   it emerges on prod. The finished result is held in DONE until the
//   consumer takes it.
//
//   Build option: define DOT_PRODUCT_ACC_SATURATE_EN to clamp the
//   accumulator to all-ones on overflow; by default it wraps modulo 2^ACC_W.
//   ovf is sticky per result in both builds.
//
// Parameters
//   WIDTH   operand width of the companion multiplier
//   COUNT   products per result (1..15)
//   LATENCY cycles from operand acceptance to a valid product (>= 1)
//   ACC_W   accumulator / result width
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair presented to the multiplier this cycle
//   in_ready   block accepts an operand pair this cycle
//   prod       multiplier output
//   acc_out    completed dot-product result
//   out_valid  acc_out holds a completed result
//   out_ready  consumer takes the result
//   ovf        current or held result overflowed ACC_W
//
// state | meaning
// ACCUM | issuing operand pairs and summing returning products
// DONE  | result complete and held until out_ready

module dot_product_acc #(
  parameter int WIDTH   = 4,
  parameter int COUNT   = 4,
  parameter int LATENCY = 2,
  parameter int ACC_W   = 2*WIDTH+2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] prod,
  output logic [ACC_W-1:0]   acc_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               ovf
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [3:0] CNT_LIM  = 4'(COUNT);
  localparam logic [3:0] CNT_LAST = 4'(COUNT-1);

  state_t             state, state_nxt;
  logic [3:0]         issued, received;
  logic [LATENCY-1:0] vld;
  logic [ACC_W-1:0]   acc;
  logic               ovf_q;
  logic               accept, add, clear;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_sum;

  assign accept = in_valid & in_ready;
  // The oldest delay-line stage marks the cycle its product is on prod.
  assign add    = vld[LATENCY-1];

  // Extra top bit captures the carry out of ACC_W.
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

`ifdef DOT_PRODUCT_ACC_SATURATE_EN
  assign acc_sum = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_sum = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clear     = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = (issued < CNT_LIM);
        if (add && (received == CNT_LAST))
          state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clear     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      vld      <= '0;
      acc      <= '0;
      issued   <= '0;
      received <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      // Written as a shift-in so a single-stage line (LATENCY=1) also works.
      vld   <= (vld << 1) | LATENCY'(accept);
      if (clear) begin
        acc      <= '0;
        issued   <= '0;
        received <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (accept)
          issued <= issued + 4'd1;
        if (add) begin
          acc      <= acc_sum;
          received <= received + 4'd1;
          if (sum[ACC_W])
            ovf_q <= 1'b1;
        end
      end
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;

endmodule

// File: doc/dot_product_acc.md
DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width of the companion multiplier.
REQ-002 SHALL have parameter COUNT, default 4, legal range 1..15: number of products summed per result.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from operand acceptance to a valid multiplier product.
REQ-004 SHALL have parameter ACC_W, default 2*WIDTH+2: accumulator and result width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the operand pair is being presented to the multiplier this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-009 SHALL have port prod, input, 2*WIDTH bits: the multiplier output y.
REQ-010 SHALL have port acc_out, output, ACC_W bits: the completed dot-product result.
REQ-011 SHALL have port out_valid, output, 1 bit: acc_out holds a completed result.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port ovf, output, 1 bit: the current or held result overflowed ACC_W.

Function
REQ-014 SHALL accept an operand pair when in_valid and in_ready are both high at a rising edge; in_valid while in_ready is low SHALL be ignored.
REQ-015 SHALL propagate each accept through a LATENCY-stage valid delay line; the product SHALL be added to the accumulator at edge t+LATENCY for an accept at edge t.
REQ-016 SHALL implement states ACCUM and DONE.
REQ-017 In ACCUM, in_ready SHALL be high while the issued count is below COUNT and low otherwise.
REQ-018 ACCUM SHALL move to DONE at the edge that adds the COUNT-th product; out_valid SHALL be high exactly while in DONE.
REQ-019 In DONE, in_ready SHALL be low, and acc_out and ovf SHALL be held stable until out_valid and out_ready are both high.
REQ-020 On a DONE handshake edge, the block SHALL clear the accumulator, the issued and received counts, and ovf, and return to ACCUM; in_ready SHALL be high in the next cycle.
REQ-021 The issued and received counters SHALL each be 4 bits wide and SHALL never exceed COUNT.
REQ-022 The block SHALL zero-extend prod to ACC_W before adding.
REQ-023 ovf SHALL be set, and stay set (sticky), when any addition carries out of ACC_W.
REQ-024 Back-to-back accepts SHALL sustain one product per cycle with no bubbles inside a result.
REQ-025 When COUNT=1, the single product SHALL go directly to DONE, LATENCY edges after its accept.

Reset
REQ-026 While rst is high at an edge, the block SHALL set state to ACCUM; accumulator, counters, delay line, ovf and out_valid to 0; and in_ready to 1 from the next cycle.
REQ-027 A reset mid-operation SHALL discard in-flight products; prod values arriving after reset without a post-reset accept SHALL NOT be added.

Configuration
REQ-028 Macro DOT_PRODUCT_ACC_SATURATE_EN SHALL select how an overflowing addition is handled.
REQ-029 With DOT_PRODUCT_ACC_SATURATE_EN defined, an overflowing addition SHALL clamp the accumulator to all-ones, and later additions SHALL keep it at all-ones.
REQ-030 Without DOT_PRODUCT_ACC_SATURATE_EN, the accumulator SHALL wrap modulo 2^ACC_W; ovf behaviour SHALL be the same in both builds.

Verification
REQ-031 Basic result (defaults, ACC_W=10): accept (3,5),(2,7),(15,15),(1,1) on consecutive edges -> out_valid high 2 cycles after the last accept, acc_out=255, ovf=0.
REQ-032 Saturating build (COUNT=8): eight accepts of (15,15) -> acc_out=1023, ovf=1.
REQ-033 Wrapping build (COUNT=8): eight accepts of (15,15) -> acc_out=776, ovf=1.
REQ-034 Backpressure: hold out_ready low for 5 cycles in DONE -> acc_out stable and in_ready low throughout; one out_ready pulse -> next cycle out_valid=0, in_ready=1.
REQ-035 Ignored input: in_valid held high during DONE with prod=225 -> next result unaffected; after drain, (1,1)x4 -> acc_out=4.
REQ-036 Reset mid-operation: two accepts of (15,15), rst pulsed one cycle, then (1,1)x4 -> acc_out=4, ovf=0.
